// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter with optional parity and per-frame bit-time prescale
//
// Purpose: serialises one DATA_WIDTH-bit word per frame as
//   start(0), data LSB first, optional parity, stop(1).
// Each bit lasts prescale+1 clock cycles. The word and the frame options are
// captured when the frame is accepted and held until the frame ends.
//
// Ports:
//   clk_i         clock, all state on its rising edge
//   rst_i         asynchronous active-high reset
//   p_data_i      word to transmit
//   data_valid_i  send request, only looked at while idle
//   par_en_i      1 = insert a parity bit after the data bits
//   par_typ_i     parity type, 0 = even, 1 = odd
//   prescale_i    bit time minus one, in clock cycles
//   tx_out_o      serial line, straight from a flop, idles high
//   busy_o        high while a frame is in progress
module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] p_data_i,
   input  logic                  data_valid_i,
   input  logic                  par_en_i,
   input  logic                  par_typ_i,
   input  logic [4:0]            prescale_i,
   output logic                  tx_out_o,
   output logic                  busy_o
);

   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic [4:0]            prescale_q;
   logic [4:0]            timer_q;
   logic [4:0]            timer_d;
   logic [IW-1:0]         idx_q;
   logic [IW-1:0]         idx_d;
   logic                  tx_q;
   logic                  busy_q;
   logic                  bit_done;
   logic                  parity_bit;

   // The last cycle of the current bit is the one where the timer has
   // reached the captured prescale; prescale=0 makes every cycle a bit end.
   assign bit_done   = (timer_q == prescale_q);
   assign timer_d    = bit_done ? 5'd0 : timer_q + 5'd1;
   assign idx_d      = idx_q + IW'(1);
   assign parity_bit = (^data_q) ^ par_typ_q;

   // tx_q is loaded with the value of the bit being entered, so the line
   // changes on the same edge as the state and never passes through logic.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         prescale_q <= 5'd0;
         timer_q    <= 5'd0;
         idx_q      <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               timer_q <= 5'd0;
               idx_q   <= '0;
               if (data_valid_i) begin
                  data_q     <= p_data_i;
                  par_en_q   <= par_en_i;
                  par_typ_q  <= par_typ_i;
                  prescale_q <= prescale_i;
                  state_q    <= START;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
               end else begin
                  tx_q   <= 1'b1;
                  busy_q <= 1'b0;
               end
            end
            START: begin
               timer_q <= timer_d;
               if (bit_done) begin
                  state_q <= DATA;
                  idx_q   <= '0;
                  tx_q    <= data_q[0];
               end
            end
            DATA: begin
               timer_q <= timer_d;
               if (bit_done) begin
                  if (idx_q == IW'(DATA_WIDTH - 1)) begin
                     if (par_en_q) begin
                        state_q <= PARITY;
                        tx_q    <= parity_bit;
                     end else begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                     end
                  end else begin
                     idx_q <= idx_d;
                     tx_q  <= data_q[idx_d];
                  end
               end
            end
            PARITY: begin
               timer_q <= timer_d;
               if (bit_done) begin
                  state_q <= STOP;
                  tx_q    <= 1'b1;
               end
            end
            STOP: begin
               timer_q <= timer_d;
               if (bit_done) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_out_o = tx_q;
   assign busy_o   = busy_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 p_data  input  DATA_WIDTH  parallel byte to transmit.
REQ-005 data_valid  input  1  request to send p_data; sampled only when busy=0.
REQ-006 par_en  input  1  1 = a parity bit is inserted after the data bits.
REQ-007 par_typ  input  1  parity type: 0 = even, 1 = odd.
REQ-008 prescale  input  5  each bit lasts prescale+1 clk cycles (range 1..32).
REQ-009 tx_out  output  1  serial line, registered, idles high.
REQ-010 busy  output  1  registered, high while a frame is in progress.

Function
REQ-011 The frame SHALL be: start bit 0, then DATA_WIDTH data bits LSB first, then parity if par_en=1, then one stop bit 1.
REQ-012 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-013 In IDLE, tx_out SHALL be 1 and busy SHALL be 0.
REQ-014 In IDLE, data_valid=1 at a rising edge SHALL latch p_data, par_en, par_typ and prescale, and SHALL move the FSM to START.
- From that same edge, tx_out=0 and busy=1.
- Latency: one clock.
REQ-015 Inputs SHALL NOT be sampled again until the frame ends; changes to p_data, par_en, par_typ, prescale or data_valid mid-frame SHALL have no effect.
REQ-016 A 5-bit bit-timer SHALL count 0..latched prescale.
- Each state SHALL hold tx_out constant for exactly prescale+1 cycles.
- The state SHALL advance on the edge where the timer equals prescale; the timer SHALL then reset to 0.
REQ-017 A bit index SHALL count 0..DATA_WIDTH-1 in DATA, and DATA SHALL drive bit[index] of the latched byte.
- DATA SHALL go to PARITY after the last bit if the latched par_en=1.
- Otherwise DATA SHALL go to STOP.
REQ-018 The parity bit SHALL be the XOR of the latched data when par_typ=0, and its inverse when par_typ=1.
REQ-019 STOP SHALL drive tx_out=1 for prescale+1 cycles, then go to IDLE with busy=0.
- Total frame length SHALL be (DATA_WIDTH+2+par_en)*(prescale+1) cycles.
REQ-020 Back-to-back frames: data_valid held high SHALL be accepted in the first IDLE cycle.
- This gives exactly one idle cycle (tx_out=1, busy=0) between frames.
REQ-021 prescale=0 SHALL give one clock per bit with no special-casing.
REQ-022 tx_out SHALL be glitch-free, driven directly from a flop.

Reset
REQ-023 When rst=1, asynchronously and regardless of clk: FSM=IDLE, tx_out=1, busy=0, timer=0, bit index=0, data register=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately.
- After release, no partial frame SHALL resume.
- The next frame SHALL start only on a new data_valid.
REQ-025 The first rising edge after rst deasserts SHALL behave as normal IDLE sampling.

Verification
REQ-026 Odd parity: p_data=8'b1001_1011, par_en=1, par_typ=1, prescale=7, data_valid pulsed for 1 cycle.
- tx_out SHALL be 0,1,1,0,1,1,0,0,1,0,1, each held 8 cycles.
- busy SHALL be high for 88 cycles.
REQ-027 Even parity: same byte with par_typ=0 -> parity bit SHALL be 1; frame still 88 cycles.
REQ-028 No parity: par_en=0, p_data=8'h5A, prescale=3.
- tx_out SHALL be 0,0,1,0,1,1,0,1,0,1, each held 4 cycles.
- busy SHALL be high for 40 cycles.
REQ-029 Stability and back-to-back: data_valid held high, p_data changed mid-frame, prescale=0.
- The first frame SHALL carry the originally latched byte.
- The second frame SHALL start after exactly one idle cycle.
REQ-030 Reset mid-DATA (bit index 4): tx_out SHALL go to 1 and busy to 0 asynchronously, with no further bits after release.
REQ-031 prescale=31, par_en=1: each bit SHALL last 32 cycles and the frame 352 cycles, with the bench checking the line against a reference serial model.
